// File: rtl/vga_layer_compositor.sv
// VGA timing generator and fixed-priority layer compositor.
// Produces sync, pixel coordinates and a registered RGB word merged from LAYERS painter outputs.
//
// state | meaning
// SHOW  | all layers visible
// HIDE  | layers with blink_mask set are suppressed
module vga_layer_compositor #(
    parameter int RGB_W        = 3,
    parameter int LAYERS       = 4,
    parameter int CLK_DIV      = 4,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk_100MHz,
    input  logic                      reset_n,
    input  logic [LAYERS-1:0]         layer_on,
    input  logic [LAYERS*RGB_W-1:0]   layer_rgb,
    input  logic [LAYERS-1:0]         blink_mask,
    input  logic [RGB_W-1:0]          bg_rgb,
    output logic [9:0]                pixel_x,
    output logic [9:0]                pixel_y,
    output logic                      video_on,
    output logic                      pixel_tick,
    output logic                      frame_start,
    output logic                      hsync,
    output logic                      vsync,
    output logic [RGB_W-1:0]          rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic {SHOW, HIDE} blink_state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    blink_state_t     state_q, state_d;

    logic [LAYERS-1:0] eff_on;
    logic [RGB_W-1:0]  pix_rgb;
    logic              frame_wrap;

    assign video_on   = (x_q < H_ACT) && (y_q < V_ACT);
    assign frame_wrap = tick_q && (x_q == H_LAST) && (y_q == V_LAST);

    // Walk from lowest priority upward so the lowest hit index wins.
    always_comb begin
        eff_on = layer_on;
        if (state_q == HIDE) eff_on = layer_on & ~blink_mask;
        pix_rgb = bg_rgb;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (eff_on[i]) pix_rgb = layer_rgb[i*RGB_W +: RGB_W];
        end
    end

    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d  = (div_d == DIV_LAST);
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        fcnt_d  = fcnt_q;
        state_d = state_q;
        if (tick_q) begin
            x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
            if (x_q == H_LAST) y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            hsync_d = !((x_q >= HS_START) && (x_q < HS_END));
            vsync_d = !((y_q >= VS_START) && (y_q < VS_END));
            rgb_d   = video_on ? pix_rgb : '0;
        end
        if (frame_wrap) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                state_d = (state_q == SHOW) ? HIDE : SHOW;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
            fcnt_q  <= '0;
            state_q <= SHOW;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign pixel_tick  = tick_q;
    assign frame_start = frame_wrap;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomized bench for vga_layer_compositor on a shrunken raster so several
// blink periods and resets fit in a short run.
module tb_vga_layer_compositor;

    localparam int RGB_W   = 3;
    localparam int LAYERS  = 4;
    localparam int CLK_DIV = 4;
    localparam int HA = 16, HFP = 2, HS = 3, HB = 2;
    localparam int VA = 8,  VFP = 2, VS = 2, VB = 1;
    localparam int BF = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME_CLK = HT * VT * CLK_DIV;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic [LAYERS-1:0]       layer_on;
    logic [LAYERS*RGB_W-1:0] layer_rgb;
    logic [LAYERS-1:0]       blink_mask;
    logic [RGB_W-1:0]        bg_rgb;
    logic [9:0]              pixel_x, pixel_y;
    logic                    video_on, pixel_tick, frame_start, hsync, vsync;
    logic [RGB_W-1:0]        rgb;

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .RGB_W(RGB_W), .LAYERS(LAYERS), .CLK_DIV(CLK_DIV),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk_100MHz(clk), .reset_n(rst_n),
        .layer_on(layer_on), .layer_rgb(layer_rgb), .blink_mask(blink_mask), .bg_rgb(bg_rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .pixel_tick(pixel_tick),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_rgb = 0;
    int exp_hs = 1;
    int exp_vs = 1;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic new_inputs();
        layer_on   = ($urandom_range(0, 3) == 0) ? '0 : LAYERS'($urandom);
        layer_rgb  = (LAYERS*RGB_W)'($urandom);
        blink_mask = LAYERS'($urandom);
        bg_rgb     = RGB_W'($urandom);
    endtask

    // Reference for the pixel with linear index p since reset, using the held inputs.
    task automatic ref_pixel(input int p, output int r, output int h, output int v);
        int x, y, frame;
        bit hide;
        x = p % HT;
        y = (p / HT) % VT;
        frame = p / (HT * VT);
        hide = ((frame / BF) % 2) == 1;
        h = (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1;
        v = (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1;
        if (x >= HA || y >= VA) begin
            r = 0;
        end else begin
            r = bg_rgb;
            for (int i = 0; i < LAYERS; i++) begin
                if (layer_on[i] && !(hide && blink_mask[i])) begin
                    r = (layer_rgb >> (i * RGB_W)) & ((1 << RGB_W) - 1);
                    break;
                end
            end
        end
    endtask

    task automatic step();
        int n, ex, ey;
        bit tick_edge, tick_next;
        @(posedge clk);
        #1;
        cyc++;
        n = cyc / CLK_DIV;
        tick_edge = (cyc % CLK_DIV) == 0;
        if (tick_edge) ref_pixel(n - 1, exp_rgb, exp_hs, exp_vs);
        ex = n % HT;
        ey = (n / HT) % VT;
        tick_next = (cyc % CLK_DIV) == CLK_DIV - 1;
        chk("pixel_x", pixel_x, ex);
        chk("pixel_y", pixel_y, ey);
        chk("pixel_tick", pixel_tick, tick_next);
        chk("video_on", video_on, (ex < HA && ey < VA) ? 1 : 0);
        chk("frame_start", frame_start, (tick_next && ex == HT - 1 && ey == VT - 1) ? 1 : 0);
        chk("hsync", hsync, exp_hs);
        chk("vsync", vsync, exp_vs);
        chk("rgb", rgb, exp_rgb);
        if (tick_edge) new_inputs();
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_hsync"}, hsync, 1);
        chk({pfx, "_vsync"}, vsync, 1);
        chk({pfx, "_rgb"}, rgb, 0);
        chk({pfx, "_x"}, pixel_x, 0);
        chk({pfx, "_y"}, pixel_y, 0);
        chk({pfx, "_tick"}, pixel_tick, 0);
        chk({pfx, "_fstart"}, frame_start, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        exp_rgb = 0;
        exp_hs = 1;
        exp_vs = 1;
    endtask

    task automatic mid_run_reset(input string pfx);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values(pfx);
        release_reset();
    endtask

    initial begin
        new_inputs();
        #1 rst_n = 1'b0;
        #2;
        check_reset_values("por");
        release_reset();

        // Reset during a HIDE frame, mid active line.
        repeat (CLK_DIV * (2 * HT * VT + (VA / 2) * HT + HA / 2) + 1) step();
        mid_run_reset("rst_active");

        // Full blink cycle back to SHOW, then reset while both syncs are low.
        repeat (5 * FRAME_CLK) step();
        repeat (CLK_DIV * ((VA + VFP) * HT + HA + HFP + 1) + 1) step();
        chk("pre_rst_hsync", hsync, 0);
        chk("pre_rst_vsync", vsync, 0);
        mid_run_reset("rst_sync");

        repeat (FRAME_CLK + 3 * HT * CLK_DIV) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised VGA back end for the game display. Generates 640x480 sync timing from the 100 MHz system clock, exports the pixel coordinates to the upstream shape/text painters, and merges up to LAYERS painter outputs into one registered RGB word using fixed priority, per-layer blinking and a programmable background. Its outputs drive the board VGA connector directly. It replaces the fixed 3-bit painter/colour-config pairing with a generic, width- and layer-scalable stage.

## Interface
Parameters:
- RGB_W, 3: bits per output colour word.
- LAYERS, 4: number of overlay layers; layer 0 has highest priority.
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- BLINK_FRAMES, 30: frames per blink half-period.

Ports:
- clk_100MHz  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- layer_on  in  LAYERS  per-layer pixel-hit flags, combinational from pixel_x/pixel_y.
- layer_rgb  in  LAYERS*RGB_W  per-layer colour; layer i occupies bits [i*RGB_W +: RGB_W].
- blink_mask  in  LAYERS  1 = layer i blinks.
- bg_rgb  in  RGB_W  background colour inside the active area.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  combinational, 1 when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
- pixel_tick  out  1  one-clock strobe every CLK_DIV clocks.
- frame_start  out  1  one-clock strobe coinciding with the pixel_tick that wraps pixel_y to 0.
- hsync  out  1  registered, active-low.
- vsync  out  1  registered, active-low.
- rgb  out  RGB_W  registered composite colour.

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Tick divider: a counter 0..CLK_DIV-1 asserts pixel_tick when it reaches CLK_DIV-1, then wraps to 0.
- Counters, advanced on pixel_tick only:
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
- Sync generation on pixel_tick:
  - hsync <= 0 iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC.
  - vsync <= 0 iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC.
- Blink FSM, two states: SHOW and HIDE.
  - The frame counter (0..BLINK_FRAMES-1) increments on frame_start.
  - At terminal count it clears and the state toggles.
  - In HIDE, effective_on[i] = layer_on[i] & ~blink_mask[i]. In SHOW, effective_on = layer_on.
- Composite on pixel_tick:
  - video_on = 0: rgb <= 0.
  - Otherwise: rgb <= colour of the lowest-index layer with effective_on = 1.
  - No layer hit: rgb <= bg_rgb.
- Between ticks, rgb/hsync/vsync hold their values.
- Reset (any time, including mid-frame) asynchronously forces:
  - divider = 0, pixel_x = 0, pixel_y = 0, frame counter = 0, state = SHOW;
  - hsync = 1, vsync = 1, rgb = 0, pixel_tick = 0, frame_start = 0.
- After reset release, the first pixel_tick occurs on the CLK_DIV-th rising edge.

## Timing
- Inputs are sampled on the clock edge where pixel_tick = 1, against the pixel_x/pixel_y values present before that edge.
- rgb, hsync and vsync for coordinate (x,y) appear one clock after that edge and persist CLK_DIV clocks, so colour and sync stay aligned.
- pixel_x/pixel_y are stable for CLK_DIV clocks. Upstream combinational paths must settle within CLK_DIV-1 clocks.
- Line period = H_TOTAL*CLK_DIV clocks (3200). Frame period = V_TOTAL lines (1,680,000 clocks).
- Full blink period = 2*BLINK_FRAMES frames.
- Simultaneous layer hits are resolved by priority only; no colour mixing.
- blink_mask and bg_rgb changes take effect at the next pixel_tick; no glitch inside a pixel.

## Test plan
- Reset, then count clocks: first pixel_tick on clock 4; pixel_x = 1 after tick 1; hsync falls when pixel_x = 656 is sampled and rises at 752; line length 3200 clocks.
- Run full frame: vsync low for exactly 2 lines (y = 490, 491); frame_start once per 1,680,000 clocks; pixel_y wraps 524 -> 0.
- layer_on = 4'b0110, layer_rgb colours = {3'd4,3'd2,3'd1,3'd7}, bg = 3'd5 -> rgb = 3'd1 (layer 1). With layer_on = 0 -> rgb = 5. At x = 700 -> rgb = 0.
- blink_mask = 4'b0010, layer_on = 4'b0110 -> rgb = layer1 colour for frames 0-29, layer2 colour for frames 30-59, layer1 again at frame 60.
- Assert reset_n low mid-line at x = 300: outputs go immediately to hsync = 1, vsync = 1, rgb = 0, x = y = 0, blink state SHOW; recovery timing identical to the first scenario.
- Re-run with RGB_W = 12, LAYERS = 8, CLK_DIV = 2: line = 1600 clocks; layer 7 visible only when layers 0-6 are off.
